capture_rle: RTL and testbench

- Run-length encoder directly downstream of the sampling/trigger stage.
- Consumes that stage's AXI-stream sample output on the system clock. Merges consecutive identical samples into {run_count, sample} words.
- Emits the encoded words as an AXI-stream with tlast packet framing toward the DMA/FIFO.
- Cuts buffer usage for slowly-toggling logic-analyzer inputs.

---
 rtl/capture_rle.sv | 183 ++++++++++++++++++
 tb/tb_capture_rle.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/capture_rle.sv
// capture_rle: run-length encoder for the capture path.
// Merges consecutive identical input samples into {run_count, sample} words.
// run_count holds the number of repetitions minus one.
// Words are framed into packets of pkt_len words using m_tlast.
// A flush pulse emits the pending run with m_tlast and closes the packet.
//
// Ports:
//   clk, reset            system clock and synchronous active-high reset
//   s_tdata/s_tvalid/s_tready    AXI-stream sample input
//   m_tdata/m_tvalid/m_tready/m_tlast  AXI-stream encoded output
//                         m_tdata = {run_count[cnt_w-1:0], sample[size-1:0]}
//   flush                 single-cycle pulse: emit the pending run and close the packet
//   flush_done            one-cycle pulse when the flush has completed
//
// Optional build macro CAPTURE_RLE_STATS_EN adds two saturating 32-bit
// counters on the stat_in and stat_out ports:
//   stat_in               number of accepted input samples
//   stat_out              number of output handshakes
module capture_rle #(
  parameter int unsigned size    = 32,
  parameter int unsigned cnt_w   = 16,
  parameter int unsigned pkt_len = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [size-1:0]       s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [cnt_w+size-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  input  logic                  flush,
  output logic                  flush_done
`ifdef CAPTURE_RLE_STATS_EN
  ,
  output logic [31:0]           stat_in,
  output logic [31:0]           stat_out
`endif
);

  localparam int unsigned OUT_W  = cnt_w + size;
  localparam int unsigned WCNT_W = 16;
  localparam logic [cnt_w-1:0]  CNT_MAX   = '1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(pkt_len - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [size-1:0]    held_q, held_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   m_tdata_q, m_tdata_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic               m_tlast_q, m_tlast_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic               flush_done_q, flush_done_d;

  logic out_free;
  logic accept;
  logic last_word;

  // Handshake qualifiers; s_tready depends only on registers and m_tready.
  always_comb begin
    out_free  = !m_tvalid_q || m_tready;
    s_tready  = out_free && !(flush_pend_q && (state_q == RUN));
    accept    = s_tvalid && s_tready;
    last_word = (wcnt_q == WCNT_LAST);
  end

  // Next-state: run tracking, output register load, packet framing, flush.
  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    cnt_d        = cnt_q;
    m_tdata_d    = m_tdata_q;
    m_tvalid_d   = m_tvalid_q && !m_tready;
    m_tlast_d    = m_tlast_q;
    wcnt_d       = wcnt_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;

    // A pending flush runs before any new input; input is stalled while in RUN.
    if (flush_pend_q) begin
      if (state_q == IDLE) begin
        flush_pend_d = 1'b0;
        flush_done_d = 1'b1;
      end else if (out_free) begin
        m_tdata_d    = {cnt_q, held_q};
        m_tvalid_d   = 1'b1;
        m_tlast_d    = 1'b1;
        wcnt_d       = '0;
        state_d      = IDLE;
        flush_pend_d = 1'b0;
        flush_done_d = 1'b1;
      end
    end

    if (accept) begin
      if (state_q == IDLE) begin
        held_d  = s_tdata;
        cnt_d   = '0;
        state_d = RUN;
      end else if ((s_tdata == held_q) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + cnt_w'(1);
      end else begin
        // Run ends on a new value or a saturated count.
        m_tdata_d  = {cnt_q, held_q};
        m_tvalid_d = 1'b1;
        m_tlast_d  = last_word;
        wcnt_d     = last_word ? '0 : wcnt_q + WCNT_W'(1);
        held_d     = s_tdata;
        cnt_d      = '0;
      end
    end

    // A pulse arriving while a flush is already pending is absorbed.
    if (flush && !flush_pend_q) begin
      flush_pend_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      held_q       <= '0;
      cnt_q        <= '0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      wcnt_q       <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      cnt_q        <= cnt_d;
      m_tdata_q    <= m_tdata_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      wcnt_q       <= wcnt_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign m_tdata    = m_tdata_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tlast_q;
  assign flush_done = flush_done_q;

`ifdef CAPTURE_RLE_STATS_EN
  logic [31:0] stat_in_q, stat_in_d;
  logic [31:0] stat_out_q, stat_out_d;

  // Saturating traffic counters.
  always_comb begin
    stat_in_d  = stat_in_q;
    stat_out_d = stat_out_q;
    if (accept && (stat_in_q != '1)) begin
      stat_in_d = stat_in_q + 32'(1);
    end
    if (m_tvalid_q && m_tready && (stat_out_q != '1)) begin
      stat_out_d = stat_out_q + 32'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else begin
      stat_in_q  <= stat_in_d;
      stat_out_q <= stat_out_d;
    end
  end

  assign stat_in  = stat_in_q;
  assign stat_out = stat_out_q;
`endif

endmodule

// File: tb/tb_capture_rle.sv
// Directed bench for capture_rle (size=8, cnt_w=2, pkt_len=4).
// Table-driven vectors cover run merging, saturation, packet framing and
// backpressure; hand-written sequences cover idle flush, flush coincident
// with a differing sample, and reset mid-packet.
module tb_capture_rle;

  localparam int unsigned SW = 8;
  localparam int unsigned CW = 2;
  localparam int unsigned PL = 4;
  localparam int unsigned OW = CW + SW;

  localparam logic [SW-1:0] A = 8'hA5;
  localparam logic [SW-1:0] B = 8'h3C;
  localparam logic [SW-1:0] C = 8'h5A;
  localparam logic [SW-1:0] D = 8'h11;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          flush;
  logic          flush_done;
`ifdef CAPTURE_RLE_STATS_EN
  logic [31:0]   stat_in;
  logic [31:0]   stat_out;
`endif

  always #5 clk = ~clk;

  capture_rle #(.size(SW), .cnt_w(CW), .pkt_len(PL)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .flush      (flush),
    .flush_done (flush_done)
`ifdef CAPTURE_RLE_STATS_EN
    ,
    .stat_in    (stat_in),
    .stat_out   (stat_out)
`endif
  );

  typedef struct {
    logic          sv;
    logic [SW-1:0] sd;
    logic          fl;
    logic          mr;
    logic          e_sr;
    logic          e_mv;
    logic [OW-1:0] e_md;
    logic          e_tl;
    logic          e_fd;
  } vec_t;

  vec_t vq[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic add(input logic sv, input logic [SW-1:0] sd, input logic fl, input logic mr,
                     input logic esr, input logic emv, input logic [OW-1:0] emd,
                     input logic etl, input logic efd);
    vec_t v;
    v.sv = sv; v.sd = sd; v.fl = fl; v.mr = mr;
    v.e_sr = esr; v.e_mv = emv; v.e_md = emd; v.e_tl = etl; v.e_fd = efd;
    vq.push_back(v);
  endtask

  task automatic drive(input logic sv, input logic [SW-1:0] sd, input logic fl, input logic mr);
    s_tvalid = sv;
    s_tdata  = sd;
    flush    = fl;
    m_tready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [SW-1:0] seq[5];

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_m_tvalid", 32'(m_tvalid), 32'(1'b0));
    chk("rst_m_tdata", 32'(m_tdata), 32'(0));
    chk("rst_m_tlast", 32'(m_tlast), 32'(1'b0));
    chk("rst_flush_done", 32'(flush_done), 32'(1'b0));
    chk("rst_s_tready", 32'(s_tready), 32'(1'b1));

    // A,A,A,B then flush -> {2,A}, {0,B}+tlast
    add(1, A, 0, 1, 1, 0, 10'h000, 0, 0);
    add(1, A, 0, 1, 1, 0, 10'h000, 0, 0);
    add(1, A, 0, 1, 1, 0, 10'h000, 0, 0);
    add(1, B, 0, 1, 1, 1, 10'h2A5, 0, 0);
    add(0, 0, 1, 1, 1, 0, 10'h000, 0, 0);
    add(0, 0, 0, 1, 0, 1, 10'h03C, 1, 1);
    add(0, 0, 0, 1, 1, 0, 10'h000, 0, 0);
    // 5xA, B, flush -> {3,A} saturated, {0,A}, {0,B}+tlast
    add(1, A, 0, 1, 1, 0, 10'h000, 0, 0);
    add(1, A, 0, 1, 1, 0, 10'h000, 0, 0);
    add(1, A, 0, 1, 1, 0, 10'h000, 0, 0);
    add(1, A, 0, 1, 1, 0, 10'h000, 0, 0);
    add(1, A, 0, 1, 1, 1, 10'h3A5, 0, 0);
    add(1, B, 0, 1, 1, 1, 10'h0A5, 0, 0);
    add(0, 0, 1, 1, 1, 0, 10'h000, 0, 0);
    add(0, 0, 0, 1, 0, 1, 10'h03C, 1, 1);
    add(0, 0, 0, 1, 1, 0, 10'h000, 0, 0);
    // A,B,A,B,A,B then flush -> tlast on word 4, counter wraps, flushed word 6 tlast
    add(1, A, 0, 1, 1, 0, 10'h000, 0, 0);
    add(1, B, 0, 1, 1, 1, 10'h0A5, 0, 0);
    add(1, A, 0, 1, 1, 1, 10'h03C, 0, 0);
    add(1, B, 0, 1, 1, 1, 10'h0A5, 0, 0);
    add(1, A, 0, 1, 1, 1, 10'h03C, 1, 0);
    add(1, B, 0, 1, 1, 1, 10'h0A5, 0, 0);
    add(0, 0, 1, 1, 1, 0, 10'h000, 0, 0);
    add(0, 0, 0, 1, 0, 1, 10'h03C, 1, 1);
    add(0, 0, 0, 1, 1, 0, 10'h000, 0, 0);
    // Backpressure: pending word held stable, input stalled, nothing lost
    add(1, A, 0, 0, 1, 0, 10'h000, 0, 0);
    add(1, B, 0, 0, 1, 1, 10'h0A5, 0, 0);
    add(1, C, 0, 0, 0, 1, 10'h0A5, 0, 0);
    add(1, C, 0, 0, 0, 1, 10'h0A5, 0, 0);
    add(1, C, 0, 1, 1, 1, 10'h03C, 0, 0);
    add(0, 0, 1, 1, 1, 0, 10'h000, 0, 0);
    add(0, 0, 0, 1, 0, 1, 10'h05A, 1, 1);
    add(0, 0, 0, 1, 1, 0, 10'h000, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].sv, vq[i].sd, vq[i].fl, vq[i].mr);
      #1;
      chk($sformatf("v%0d_s_tready", i), 32'(s_tready), 32'(vq[i].e_sr));
      tick();
      chk($sformatf("v%0d_m_tvalid", i), 32'(m_tvalid), 32'(vq[i].e_mv));
      chk($sformatf("v%0d_flush_done", i), 32'(flush_done), 32'(vq[i].e_fd));
      if (vq[i].e_mv) begin
        chk($sformatf("v%0d_m_tdata", i), 32'(m_tdata), 32'(vq[i].e_md));
        chk($sformatf("v%0d_m_tlast", i), 32'(m_tlast), 32'(vq[i].e_tl));
      end
    end

    // Flush while idle: no word, single flush_done pulse
    drive(0, '0, 1, 1);
    tick();
    chk("idle_flush_mv0", 32'(m_tvalid), 32'(1'b0));
    chk("idle_flush_fd0", 32'(flush_done), 32'(1'b0));
    drive(0, '0, 0, 1);
    tick();
    chk("idle_flush_mv1", 32'(m_tvalid), 32'(1'b0));
    chk("idle_flush_fd1", 32'(flush_done), 32'(1'b1));
    tick();
    chk("idle_flush_mv2", 32'(m_tvalid), 32'(1'b0));
    chk("idle_flush_fd2", 32'(flush_done), 32'(1'b0));

    // Flush coincident with an accepted differing sample
    drive(1, A, 0, 1);
    tick();
    chk("coinc_mv0", 32'(m_tvalid), 32'(1'b0));
    drive(1, B, 1, 1);
    tick();
    chk("coinc_mv1", 32'(m_tvalid), 32'(1'b1));
    chk("coinc_md1", 32'(m_tdata), 32'(10'h0A5));
    chk("coinc_tl1", 32'(m_tlast), 32'(1'b0));
    chk("coinc_fd1", 32'(flush_done), 32'(1'b0));
    drive(0, '0, 0, 1);
    #1;
    chk("coinc_sr_stall", 32'(s_tready), 32'(1'b0));
    tick();
    chk("coinc_mv2", 32'(m_tvalid), 32'(1'b1));
    chk("coinc_md2", 32'(m_tdata), 32'(10'h03C));
    chk("coinc_tl2", 32'(m_tlast), 32'(1'b1));
    chk("coinc_fd2", 32'(flush_done), 32'(1'b1));
    tick();
    chk("coinc_mv3", 32'(m_tvalid), 32'(1'b0));
    chk("coinc_fd3", 32'(flush_done), 32'(1'b0));

    // Reset mid-packet with a word pending
    drive(1, A, 0, 0);
    tick();
    drive(1, B, 0, 0);
    tick();
    chk("rstmid_pending", 32'(m_tvalid), 32'(1'b1));
    drive(0, '0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_mv", 32'(m_tvalid), 32'(1'b0));
    chk("rstmid_md", 32'(m_tdata), 32'(0));
    chk("rstmid_tl", 32'(m_tlast), 32'(1'b0));
    chk("rstmid_sr", 32'(s_tready), 32'(1'b1));
    // Fresh run and word counter: tlast lands on the 4th word after reset
    seq[0] = C; seq[1] = D; seq[2] = C; seq[3] = D; seq[4] = C;
    for (int k = 0; k < 5; k++) begin
      drive(1, seq[k], 0, 1);
      tick();
      if (k == 0) begin
        chk("post_rst_mv0", 32'(m_tvalid), 32'(1'b0));
      end else begin
        chk($sformatf("post_rst_mv%0d", k), 32'(m_tvalid), 32'(1'b1));
        chk($sformatf("post_rst_md%0d", k), 32'(m_tdata), 32'({2'b00, seq[k-1]}));
        chk($sformatf("post_rst_tl%0d", k), 32'(m_tlast), 32'(k == 4));
      end
    end
    drive(0, '0, 0, 1);
    tick();
    chk("post_rst_drain", 32'(m_tvalid), 32'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
